rtc_bus_master: RTL

- Executes single read/write transactions on the RTC chip's multiplexed address/data bus, on behalf of the controller FSM.
- The controller issues a command (read flag, address, write data). This block sequences cs_n/a_d/rd_n/wr_n and the 8-bit AD bus, then returns read data and a done pulse.
- Sits between the controller and the top-level AD tri-state pads. The tri-state buffer itself lives at top level.

---
 rtl/rtc_bus_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: runs one read or write on the RTC chip's multiplexed
// address/data bus on behalf of the controller.
// Every output is decoded from the current state into a register. The pins
// therefore show each state one clock after the FSM enters it.
// The bus has three address phases and three data phases, then a DONE cycle.
// Optional feature macro: RTC_BUS_READ_SYNC_EN. When it is defined, ad_in goes
// through a 2-flop synchronizer before capture, and DATA_STB is 2 clocks longer.
module rtc_bus_master #(
   parameter int PHASE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       read,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       cs_n,
   output logic       a_d,
   output logic       rd_n,
   output logic       wr_n,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] ad_in
);

`ifdef RTC_BUS_READ_SYNC_EN
   localparam int STB_CYCLES = PHASE_CYCLES + 2;
`else
   localparam int STB_CYCLES = PHASE_CYCLES;
`endif
   localparam int CNT_W = $clog2(STB_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR_SET, ADDR_STB, ADDR_HLD, DATA_SET, DATA_STB, DATA_HLD, DONE
   } state_t;

   state_t           state;
   state_t           next_phase;
   logic [CNT_W-1:0] cnt;
   logic             phase_end;
   logic             read_q;
   logic [7:0]       addr_q;
   logic [7:0]       wdata_q;
   logic [7:0]       cap_data;

`ifdef RTC_BUS_READ_SYNC_EN
   logic [7:0] sync1;
   logic [7:0] sync2;

   // Two-flop synchronizer on the asynchronous pad input before read capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= ad_in;
         sync2 <= sync1;
      end
   end

   assign cap_data = sync2;
`else
   assign cap_data = ad_in;
`endif

   // Detect the last clock of the current phase and pick the phase that follows it
   always_comb begin
      phase_end  = 1'b0;
      next_phase = IDLE;
      if (state == DATA_STB) begin
         phase_end = (cnt == CNT_W'(STB_CYCLES - 1));
      end else begin
         phase_end = (cnt == CNT_W'(PHASE_CYCLES - 1));
      end
      case (state)
         ADDR_SET: next_phase = ADDR_STB;
         ADDR_STB: next_phase = ADDR_HLD;
         ADDR_HLD: next_phase = DATA_SET;
         DATA_SET: next_phase = DATA_STB;
         DATA_STB: next_phase = DATA_HLD;
         DATA_HLD: next_phase = DONE;
         default:  next_phase = IDLE;
      endcase
   end

   // Transaction FSM, phase counter and registered bus/handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         read_q  <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         cs_n    <= 1'b1;
         a_d     <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         ad_oe   <= 1'b0;
         ad_out  <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cs_n   <= 1'b1;
               a_d    <= 1'b1;
               rd_n   <= 1'b1;
               wr_n   <= 1'b1;
               ad_oe  <= 1'b0;
               ad_out <= 8'h00;
               busy   <= start;
               cnt    <= '0;
               if (start) begin
                  read_q  <= read;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  state   <= ADDR_SET;
               end
            end
            ADDR_SET, ADDR_STB, ADDR_HLD: begin
               cs_n   <= 1'b0;
               a_d    <= 1'b0;
               ad_oe  <= 1'b1;
               ad_out <= addr_q;
               rd_n   <= 1'b1;
               wr_n   <= (state != ADDR_STB);
               busy   <= 1'b1;
            end
            DATA_SET, DATA_STB, DATA_HLD: begin
               cs_n   <= 1'b0;
               a_d    <= 1'b1;
               ad_oe  <= ~read_q;
               ad_out <= read_q ? 8'h00 : wdata_q;
               rd_n   <= ~((state == DATA_STB) && read_q);
               wr_n   <= ~((state == DATA_STB) && !read_q);
               busy   <= 1'b1;
               if ((state == DATA_STB) && read_q && phase_end) begin
                  rdata <= cap_data;
               end
            end
            DONE: begin
               cs_n   <= 1'b1;
               a_d    <= 1'b1;
               rd_n   <= 1'b1;
               wr_n   <= 1'b1;
               ad_oe  <= 1'b0;
               ad_out <= 8'h00;
               done   <= 1'b1;
               busy   <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if ((state != IDLE) && (state != DONE)) begin
            if (phase_end) begin
               cnt   <= '0;
               state <= next_phase;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
